// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - Load/store sequencer for a big-endian byte-addressed memory
module load_store_unit #(
    parameter int          MEM_BYTES = 65536,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_busy,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic [31:0] data_memory_a,
    output logic        data_memory_read,
    output logic        data_memory_write,
    output logic [31:0] data_memory_out_v,
    input  logic [31:0] data_memory_in_v
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, RMW_WRITE, WRITE, DONE} state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    state_t      state, state_next;
    logic        we_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_buf, rdata_q;
    logic        req_err;
    logic [4:0]  lane_lsb;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val, merged;

    always_comb begin
        req_err = (ls_size == 2'b11)
                | ((ls_size == 2'b01) && ls_addr[0])
                | ((ls_size == 2'b10) && (ls_addr[1:0] != 2'b00))
                | ({32'd0, ls_addr} >= MEM_LIMIT);
    end

    // Big-endian: byte offset k sits at bit 8*(3-k), i.e. the inverted offset.
    always_comb begin
        lane_lsb = {~addr_q[1:0], 3'b000};
        sel_byte = data_memory_in_v[lane_lsb +: 8];
        sel_half = addr_q[1] ? data_memory_in_v[15:0] : data_memory_in_v[31:16];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{signed_q & sel_half[15]}}, sel_half};
            default: load_val = data_memory_in_v;
        endcase
        merged = word_buf;
        if (size_q == 2'b00)
            merged[lane_lsb +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[15:0] = wdata_q[15:0];
        else
            merged[31:16] = wdata_q[15:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_buf <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && ls_req) begin
                we_q     <= ls_we;
                signed_q <= ls_signed;
                size_q   <= ls_size;
                addr_q   <= ls_addr;
                wdata_q  <= ls_wdata;
                err_q    <= req_err;
            end
            if (state == CAPTURE) begin
                word_buf <= data_memory_in_v;
                if (!we_q)
                    rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        state_next        = state;
        data_memory_a     = PARK_ADDR;
        data_memory_read  = 1'b0;
        data_memory_write = 1'b0;
        data_memory_out_v = 32'd0;
        case (state)
            IDLE: begin
                if (ls_req) begin
                    if (req_err)
                        state_next = DONE;
                    else if (ls_we && ls_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                data_memory_a    = {addr_q[31:2], 2'b00};
                data_memory_read = 1'b1;
                state_next       = CAPTURE;
            end
            CAPTURE: begin
                data_memory_a    = {addr_q[31:2], 2'b00};
                data_memory_read = 1'b1;
                state_next       = we_q ? RMW_WRITE : DONE;
            end
            RMW_WRITE: begin
                data_memory_a     = {addr_q[31:2], 2'b00};
                data_memory_write = 1'b1;
                data_memory_out_v = merged;
                state_next        = DONE;
            end
            WRITE: begin
                data_memory_a     = {addr_q[31:2], 2'b00};
                data_memory_write = 1'b1;
                data_memory_out_v = wdata_q;
                state_next        = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ls_busy  = (state != IDLE);
    assign ls_done  = (state == DONE);
    assign ls_err   = (state == DONE) && err_q;
    assign ls_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - Directed self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ls_req = 1'b0, ls_we = 1'b0, ls_signed = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
    logic        ls_busy, ls_done, ls_err;
    logic [31:0] ls_rdata, data_memory_a, data_memory_out_v, data_memory_in_v;
    logic        data_memory_read, data_memory_write;

    int checks = 0, errors = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0;
    logic [31:0] last_wr_a = 32'd0;
    logic        bd_we = 1'b0;
    logic [13:0] bd_idx = 14'd0;
    logic [31:0] bd_data = 32'd0;
    logic [31:0] mem [0:16383];

    load_store_unit dut (
        .Clk(Clk), .Reset(Reset), .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_busy(ls_busy), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .data_memory_a(data_memory_a), .data_memory_read(data_memory_read),
        .data_memory_write(data_memory_write), .data_memory_out_v(data_memory_out_v),
        .data_memory_in_v(data_memory_in_v)
    );

    always #5 Clk = ~Clk;

    // Memory model: registered read data, write on the clock edge.
    always @(posedge Clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (data_memory_read) begin
            rd_cnt <= rd_cnt + 1;
            data_memory_in_v <= (data_memory_a < 32'h10000) ? mem[data_memory_a[15:2]] : 32'hDEAD_BEEF;
        end
        if (data_memory_write) begin
            wr_cnt    <= wr_cnt + 1;
            last_wr_a <= data_memory_a;
            if (data_memory_a < 32'h10000) mem[data_memory_a[15:2]] <= data_memory_out_v;
        end
        if (ls_done) done_cnt <= done_cnt + 1;
        if (data_memory_write && data_memory_read) both_cnt <= both_cnt + 1;
    end

    task poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge Clk);
        bd_we = 1'b1; bd_idx = addr[15:2]; bd_data = data;
        @(negedge Clk);
        bd_we = 1'b0;
    endtask

    task do_op(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
               input logic [31:0] wdata, output int lat, output logic err);
        @(negedge Clk);
        ls_we = we; ls_size = size; ls_signed = sgn; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        @(negedge Clk);
        ls_req = 1'b0;
        lat = 0;
        while (!ls_done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        err = ls_err;
        @(negedge Clk);
    endtask

    task test_reset;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (ls_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ls_busy); end
        checks++; if (ls_done !== 1'b0 || ls_err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", ls_done, ls_err); end
        checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ls_rdata); end
        checks++; if (data_memory_a !== PARK) begin errors++; $display("FAIL reset_addr: got %h expected %h", data_memory_a, PARK); end
        checks++; if (data_memory_read !== 1'b0 || data_memory_write !== 1'b0 || data_memory_out_v !== 32'd0) begin
            errors++; $display("FAIL reset_mem_port: got r=%b w=%b v=%h expected 0 0 0", data_memory_read, data_memory_write, data_memory_out_v); end
    endtask

    task test_loads;
        int lat; logic err;
        logic [31:0] a [4] = '{32'h201, 32'h201, 32'h202, 32'h200};
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_7F01, 32'hFFFF_80FF};
        poke(32'h100, 32'h1122_3344);
        poke(32'h200, 32'h80FF_7F01);
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, err);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_word_latency: got %0d expected 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_word_err: got %b expected 0", err); end
        checks++; if (ls_rdata !== 32'h1122_3344) begin errors++; $display("FAIL load_word_data: got %h expected 11223344", ls_rdata); end
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, sz[i], sg[i], a[i], 32'd0, lat, err);
            checks++; if (lat !== 2) begin errors++; $display("FAIL subload_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (ls_rdata !== ex[i]) begin errors++; $display("FAIL subload_data[%0d]: got %h expected %h", i, ls_rdata, ex[i]); end
        end
    endtask

    task test_stores;
        int lat, w0; logic err;
        poke(32'h300, 32'hAABB_CCDD);
        w0 = wr_cnt;
        do_op(1'b1, 2'b00, 1'b0, 32'h302, 32'h1234_5677, lat, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_byte_latency: got %0d expected 3", lat); end
        checks++; if (mem[14'hC0] !== 32'hAABB_77DD) begin errors++; $display("FAIL store_byte_word: got %h expected AABB77DD", mem[14'hC0]); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL store_byte_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (last_wr_a !== 32'h300) begin errors++; $display("FAIL store_byte_addr: got %h expected 00000300", last_wr_a); end
        checks++; if (ls_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL store_keeps_rdata: got %h expected FFFF80FF", ls_rdata); end
        do_op(1'b1, 2'b01, 1'b0, 32'h300, 32'h0000_BEEF, lat, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_half_latency: got %0d expected 3", lat); end
        checks++; if (mem[14'hC0] !== 32'hBEEF_77DD) begin errors++; $display("FAIL store_half_word: got %h expected BEEF77DD", mem[14'hC0]); end
        do_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_CCDD, lat, err);
        checks++; if (mem[14'hC0] !== 32'hBEEF_CCDD) begin errors++; $display("FAIL store_half_low: got %h expected BEEFCCDD", mem[14'hC0]); end
        w0 = wr_cnt;
        do_op(1'b1, 2'b10, 1'b0, 32'h304, 32'h0123_4567, lat, err);
        checks++; if (lat !== 1) begin errors++; $display("FAIL store_word_latency: got %0d expected 1", lat); end
        checks++; if (mem[14'hC1] !== 32'h0123_4567 || wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL store_word: got %h writes %0d expected 01234567 writes 1", mem[14'hC1], wr_cnt - w0); end
    endtask

    task test_errors;
        int lat, r0, w0; logic err;
        logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] a  [4] = '{32'h101, 32'h102, 32'h100, 32'h1_0000};
        for (int i = 0; i < 4; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            do_op(we[i], sz[i], 1'b0, a[i], 32'h5555_5555, lat, err);
            checks++; if (lat !== 0 || err !== 1'b1) begin errors++; $display("FAIL reject[%0d]: got lat %0d err %b expected lat 0 err 1", i, lat, err); end
            checks++; if (rd_cnt != r0 || wr_cnt != w0) begin errors++; $display("FAIL reject_mem[%0d]: got %0d reads %0d writes expected 0 0", i, rd_cnt - r0, wr_cnt - w0); end
            checks++; if (ls_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL reject_rdata[%0d]: got %h expected FFFF80FF", i, ls_rdata); end
        end
    endtask

    task test_back_to_back;
        int lat, d0, w0; logic err;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, err);
        checks++; if (ls_rdata !== 32'h1122_3344) begin errors++; $display("FAIL b2b_first: got %h expected 11223344", ls_rdata); end
        checks++; if (data_memory_a !== PARK) begin errors++; $display("FAIL b2b_park: got %h expected %h", data_memory_a, PARK); end
        do_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D, lat, err);
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, err);
        checks++; if (ls_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_second: got %h expected CAFEF00D", ls_rdata); end
        d0 = done_cnt; w0 = wr_cnt;
        @(negedge Clk);
        ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h104; ls_wdata = 32'h5A5A_5A5A; ls_req = 1'b1;
        lat = 0;
        while (!ls_done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        ls_req = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (lat !== 2) begin errors++; $display("FAIL held_req_latency: got %0d expected 2", lat); end
        checks++; if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL held_req_once: got %0d done %0d writes expected 1 1", done_cnt - d0, wr_cnt - w0); end
        checks++; if (mem[14'h41] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL held_req_data: got %h expected 5A5A5A5A", mem[14'h41]); end
    endtask

    task test_reset_abort;
        int d0, w0;
        d0 = done_cnt; w0 = wr_cnt;
        @(negedge Clk);
        ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h301; ls_wdata = 32'h0000_00FF; ls_req = 1'b1;
        @(negedge Clk);
        ls_req = 1'b0;
        @(negedge Clk);
        checks++; if (data_memory_read !== 1'b1 || ls_busy !== 1'b1) begin errors++; $display("FAIL abort_capture: got r=%b busy=%b expected 1 1", data_memory_read, ls_busy); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (ls_busy !== 1'b0 || ls_done !== 1'b0 || ls_err !== 1'b0 || ls_rdata !== 32'd0) begin
            errors++; $display("FAIL abort_outputs: got busy=%b done=%b err=%b rdata=%h expected 0 0 0 0", ls_busy, ls_done, ls_err, ls_rdata); end
        checks++; if (data_memory_a !== PARK || data_memory_read !== 1'b0 || data_memory_write !== 1'b0 || data_memory_out_v !== 32'd0) begin
            errors++; $display("FAIL abort_mem_port: got a=%h r=%b w=%b v=%h expected park 0 0 0", data_memory_a, data_memory_read, data_memory_write, data_memory_out_v); end
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (mem[14'hC0] !== 32'hBEEF_CCDD || wr_cnt != w0 || done_cnt != d0) begin
            errors++; $display("FAIL abort_effects: got word %h writes %0d done %0d expected BEEFCCDD 0 0", mem[14'hC0], wr_cnt - w0, done_cnt - d0); end
        Reset = 1'b1;
        ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h308; ls_wdata = 32'h7777_7777; ls_req = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; ls_req = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (ls_busy !== 1'b0 || wr_cnt != w0 || done_cnt != d0) begin
            errors++; $display("FAIL reset_with_req: got busy=%b writes %0d done %0d expected 0 0 0", ls_busy, wr_cnt - w0, done_cnt - d0); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_errors;
        test_back_to_back;
        test_reset_abort;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL read_during_write: got %0d cycles expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
